poly_coef_mem: RTL

//  Parametrised coefficient store for one SNTRUP757 polynomial operand or result.

---
 rtl/poly_coef_mem_pkg.sv | 15 +
 rtl/poly_coef_mem_if.sv | 29 ++
 rtl/poly_coef_mem_coef_ram_dp.sv | 24 ++
 rtl/poly_coef_mem.sv | 137 +++++++++++++
 4 files changed

// File: rtl/poly_coef_mem_pkg.sv
// Shared types and default sizing for the SNTRUP757 coefficient store.
package sntrup_pkg;

    localparam int COEF_W = 26;
    localparam int ADDR_W = 11;
    localparam int N_COEF = 757;

    typedef logic [10:0] deg_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/poly_coef_mem_if.sv
// Control, read/write and degree signals of one coefficient store.
interface poly_coef_mem_if;
    import sntrup_pkg::*;

    logic              clr;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [COEF_W-1:0] rd_data;
    logic              rd_valid;
    logic              deg_ld;
    deg_t              deg_i;
    deg_t              deg_o;
    logic              addr_err;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr, deg_ld, deg_i,
        input  busy, rd_data, rd_valid, deg_o, addr_err
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr, deg_ld, deg_i,
        output busy, rd_data, rd_valid, deg_o, addr_err
    );

endinterface

// File: rtl/poly_coef_mem_coef_ram_dp.sv
// Plain one-write / one-read distributed RAM with asynchronous read.
module coef_ram_dp #(
    parameter int DW = 26,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/poly_coef_mem.sv
// Coefficient store with zero-fill sweep, registered read, degree tracking and range check.
// MEM_RD_REG_EN adds a second read output register (read latency 2 instead of 1).
module poly_coef_mem
    import sntrup_pkg::*;
#(
    parameter int N_COEF = sntrup_pkg::N_COEF
) (
    input  logic           clk,
    input  logic           rst_n,
    poly_coef_mem_if.slave bus
);

    localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(N_COEF);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_COEF - 1);

    mem_state_t        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_err;
    deg_t              r_deg;
    logic              r_rd_valid;
    logic [COEF_W-1:0] r_rd_data;

    logic              w_ready;
    logic              w_wr_in;
    logic              w_rd_in;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_oor;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [COEF_W-1:0] w_ram_wdata;
    logic [COEF_W-1:0] w_ram_rdata;

    // A clr pulse takes priority over any access presented in the same cycle.
    assign w_ready = (r_state == READY) && !bus.clr;
    assign w_wr_in = ({1'b0, bus.wr_addr} < LIM);
    assign w_rd_in = ({1'b0, bus.rd_addr} < LIM);
    assign w_wr_ok = w_ready && bus.wr_en && w_wr_in;
    assign w_rd_ok = w_ready && bus.rd_en && w_rd_in;
    assign w_oor   = w_ready && ((bus.wr_en && !w_wr_in) || (bus.rd_en && !w_rd_in));

    assign w_ram_we    = (r_state == CLEAR) || w_wr_ok;
    assign w_ram_waddr = (r_state == CLEAR) ? r_cnt : bus.wr_addr;
    assign w_ram_wdata = (r_state == CLEAR) ? '0 : bus.wr_data;

    coef_ram_dp #(
        .DW (COEF_W),
        .AW (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (w_ram_waddr),
        .wdata (w_ram_wdata),
        .raddr (bus.rd_addr),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_deg   <= '0;
        end else if (bus.clr) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_deg   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_cnt == LAST) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READY: begin
                    if (w_oor) begin
                        r_err <= 1'b1;
                    end
                end
            endcase
            // An explicit degree load beats tracking from a simultaneous write.
            if (bus.deg_ld) begin
                r_deg <= bus.deg_i;
            end else if (w_wr_ok && (bus.wr_data != '0) && (bus.wr_addr > r_deg)) begin
                r_deg <= bus.wr_addr;
            end
        end
    end

    // The RAM read is sampled on the same edge as a write, so it returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_data <= w_ram_rdata;
            end
        end
    end

`ifdef MEM_RD_REG_EN
    logic              r_rd_valid2;
    logic [COEF_W-1:0] r_rd_data2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid2 <= 1'b0;
            r_rd_data2  <= '0;
        end else begin
            r_rd_valid2 <= r_rd_valid;
            if (r_rd_valid) begin
                r_rd_data2 <= r_rd_data;
            end
        end
    end

    assign bus.rd_valid = r_rd_valid2;
    assign bus.rd_data  = r_rd_data2;
`else
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
`endif

    assign bus.busy     = r_busy;
    assign bus.deg_o    = r_deg;
    assign bus.addr_err = r_err;

endmodule
